// File: rtl/lifo_ctrl_if.sv
// lifo_ctrl_if: request and stack-side signal bundle for lifo_ctrl.
// slave  = the controller's view (drives in_ready, outputs and stack strobes).
// master = the view of the surrounding logic that drives requests and q.
interface lifo_ctrl_if #(
    parameter int Wl = 6,
    parameter int N  = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [Wl-1:0] in_data;
    logic          rd_req;
    logic          err_clr;
    logic          out_valid;
    logic [Wl-1:0] out_data;
    logic          push;
    logic          pop;
    logic [Wl-1:0] dio;
    logic [Wl-1:0] q;
    logic [N:0]    count;
    logic          full;
    logic          empty;
    logic          error;

    modport slave (
        input  in_valid, in_data, rd_req, err_clr, q,
        output in_ready, out_valid, out_data, push, pop, dio,
               count, full, empty, error
    );

    modport master (
        output in_valid, in_data, rd_req, err_clr, q,
        input  in_ready, out_valid, out_data, push, pop, dio,
               count, full, empty, error
    );
endinterface

// File: rtl/lifo_ctrl.sv
// lifo_ctrl: turns a valid/ready write stream and a level read request into
// single-cycle push/pop pulses for an attached lifo_stack. It tracks occupancy,
// captures popped words and keeps a sticky underflow flag.
// Optional build macro LIFO_CTRL_OVF_ERR_EN: an offered word while full also
// sets the sticky error (the stall itself is unchanged).
module lifo_ctrl #(
    parameter int Wl = 6,
    parameter int N  = 3
) (
    input  logic        clk,
    input  logic        reset,
    lifo_ctrl_if.slave  bus
);
    localparam int         DEPTH      = 2 ** N;
    localparam logic [N:0] COUNT_FULL = (N + 1)'(DEPTH);
    localparam logic [N:0] COUNT_ONE  = (N + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        WAIT,
        CAPT
    } state_t;

    state_t        state_q;
    logic          push_q;
    logic          pop_q;
    logic          out_valid_q;
    logic          error_q;
    logic [Wl-1:0] dio_q;
    logic [Wl-1:0] out_data_q;
    logic [N:0]    count_q;

    logic          full;
    logic          empty;
    logic          in_ready;
    logic          accept;
    logic          rd_issue;
    logic          err_set;
    logic          error_d;

    // Decode flags, handshake and the sticky-error next value from current state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        full     = (count_q == COUNT_FULL);
        empty    = (count_q == '0);
        in_ready = (state_q == IDLE) && !full;
        accept   = in_ready && bus.in_valid;
        // A push accepted on this edge wins over a simultaneous read request.
        rd_issue = (state_q == IDLE) && !accept && bus.rd_req && !empty;
        err_set  = (state_q == IDLE) && !accept && bus.rd_req && empty;
`ifdef LIFO_CTRL_OVF_ERR_EN
        err_set  = err_set || ((state_q == IDLE) && bus.in_valid && full);
`endif
        // Set beats clear when both land on the same edge.
        error_d  = err_set || (error_q && !bus.err_clr);
    end

    // Request sequencer: issues push/pop pulses, tracks count, captures q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            dio_q       <= '0;
            out_data_q  <= '0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            out_valid_q <= 1'b0;
            error_q     <= error_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        dio_q   <= bus.in_data;
                        push_q  <= 1'b1;
                        count_q <= count_q + COUNT_ONE;
                        state_q <= PUSH;
                    end else if (rd_issue) begin
                        pop_q   <= 1'b1;
                        count_q <= count_q - COUNT_ONE;
                        state_q <= POP;
                    end
                end
                PUSH: state_q <= IDLE;
                // The stack samples pop on the edge that leaves POP.
                POP:  state_q <= WAIT;
                // The stack's registered q settles during WAIT.
                WAIT: state_q <= CAPT;
                CAPT: begin
                    out_data_q  <= bus.q;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.push      = push_q;
    assign bus.pop       = pop_q;
    assign bus.dio       = dio_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_lifo_ctrl.sv
// tb_lifo_ctrl: directed bench for lifo_ctrl with a small lifo_stack model
// driving q. A vector table covers the LIFO-order sequence cycle by cycle;
// hand-written sequences cover fill/stall, underflow, push priority and reset
// in the middle of a read.
module tb_lifo_ctrl;
    localparam int Wl = 6;
    localparam int N  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    lifo_ctrl_if #(.Wl(Wl), .N(N)) bus ();

    lifo_ctrl #(.Wl(Wl), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural lifo_stack: registered q updated on the pop edge.
    logic [Wl-1:0] mem [8];
    int            sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= 0;
            bus.q <= '0;
        end else if (bus.push && sp < 8) begin
            mem[sp] <= bus.dio;
            sp      <= sp + 1;
        end else if (bus.pop && sp > 0) begin
            bus.q <= mem[sp-1];
            sp    <= sp - 1;
        end
    end

    // Pulse counters sampled mid-cycle.
    int push_cnt = 0;
    int pop_cnt  = 0;
    int ov_cnt   = 0;
    always @(negedge clk) begin
        if (bus.push)      push_cnt <= push_cnt + 1;
        if (bus.pop)       pop_cnt  <= pop_cnt + 1;
        if (bus.out_valid) ov_cnt   <= ov_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_req   = 1'b0;
        bus.err_clr  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [Wl-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic wait_ov(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_ov_seen"}, 32'(got), 32'd1);
    endtask

    typedef struct {
        logic          iv;
        logic [Wl-1:0] d;
        logic          rd;
        logic          clr;
        logic          ir;
        logic          push;
        logic          pop;
        logic          ov;
        logic [Wl-1:0] od;
        logic [N:0]    cnt;
        logic          full;
        logic          empty;
        logic          err;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [Wl-1:0] d, input logic rd,
                                input logic ir, input logic ps, input logic pp, input logic ov,
                                input logic [Wl-1:0] od, input logic [N:0] cnt, input logic em);
        vec_t v;
        v.iv = iv; v.d = d; v.rd = rd; v.clr = 1'b0;
        v.ir = ir; v.push = ps; v.pop = pp; v.ov = ov; v.od = od; v.cnt = cnt;
        v.full = 1'b0; v.empty = em; v.err = 1'b0;
        return v;
    endfunction

    vec_t tbl [19];
    int   p0;
    logic exp_ovf_err;

    initial begin
        // LIFO order: push 7, 5, 23 then hold rd_req across three reads.
        //            iv d   rd  ir ps pp ov od  cnt em
        tbl[0]  = mk(1, 7,  0,  0, 1, 0, 0, 0,  1, 0);
        tbl[1]  = mk(0, 0,  0,  1, 0, 0, 0, 0,  1, 0);
        tbl[2]  = mk(1, 5,  0,  0, 1, 0, 0, 0,  2, 0);
        tbl[3]  = mk(0, 0,  0,  1, 0, 0, 0, 0,  2, 0);
        tbl[4]  = mk(1, 23, 0,  0, 1, 0, 0, 0,  3, 0);
        tbl[5]  = mk(0, 0,  0,  1, 0, 0, 0, 0,  3, 0);
        tbl[6]  = mk(0, 0,  1,  0, 0, 1, 0, 0,  2, 0);
        tbl[7]  = mk(0, 0,  1,  0, 0, 0, 0, 0,  2, 0);
        tbl[8]  = mk(0, 0,  1,  0, 0, 0, 0, 0,  2, 0);
        tbl[9]  = mk(0, 0,  1,  1, 0, 0, 1, 23, 2, 0);
        tbl[10] = mk(0, 0,  1,  0, 0, 1, 0, 23, 1, 0);
        tbl[11] = mk(0, 0,  1,  0, 0, 0, 0, 23, 1, 0);
        tbl[12] = mk(0, 0,  1,  0, 0, 0, 0, 23, 1, 0);
        tbl[13] = mk(0, 0,  1,  1, 0, 0, 1, 5,  1, 0);
        tbl[14] = mk(0, 0,  1,  0, 0, 1, 0, 5,  0, 1);
        tbl[15] = mk(0, 0,  1,  0, 0, 0, 0, 5,  0, 1);
        tbl[16] = mk(0, 0,  1,  0, 0, 0, 0, 5,  0, 1);
        tbl[17] = mk(0, 0,  1,  1, 0, 0, 1, 7,  0, 1);
        tbl[18] = mk(0, 0,  0,  1, 0, 0, 0, 7,  0, 1);

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_req   = 1'b0;
        bus.err_clr  = 1'b0;
        #2;
        // Reset state while reset is held.
        check("rst_push",  32'(bus.push),      32'd0);
        check("rst_pop",   32'(bus.pop),       32'd0);
        check("rst_ov",    32'(bus.out_valid), 32'd0);
        check("rst_od",    32'(bus.out_data),  32'd0);
        check("rst_dio",   32'(bus.dio),       32'd0);
        check("rst_count", 32'(bus.count),     32'd0);
        check("rst_empty", 32'(bus.empty),     32'd1);
        check("rst_full",  32'(bus.full),      32'd0);
        check("rst_error", 32'(bus.error),     32'd0);
        do_reset();

        // Table-driven LIFO-order sequence.
        for (int i = 0; i < 19; i++) begin
            bus.in_valid = tbl[i].iv;
            bus.in_data  = tbl[i].d;
            bus.rd_req   = tbl[i].rd;
            bus.err_clr  = tbl[i].clr;
            step();
            check($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),  32'(tbl[i].ir));
            check($sformatf("v%0d_push", i),      32'(bus.push),      32'(tbl[i].push));
            check($sformatf("v%0d_pop", i),       32'(bus.pop),       32'(tbl[i].pop));
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            check($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(tbl[i].od));
            check($sformatf("v%0d_count", i),     32'(bus.count),     32'(tbl[i].cnt));
            check($sformatf("v%0d_full", i),      32'(bus.full),      32'(tbl[i].full));
            check($sformatf("v%0d_empty", i),     32'(bus.empty),     32'(tbl[i].empty));
            check($sformatf("v%0d_error", i),     32'(bus.error),     32'(tbl[i].err));
        end

        // Fill to DEPTH, stall a 9th word, then read the top back.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(6'(10 + i));
        check("fill_count",    32'(bus.count),    32'd8);
        check("fill_full",     32'(bus.full),     32'd1);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_empty",    32'(bus.empty),    32'd0);
        p0 = push_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h3f;
        repeat (10) step();
        check("stall_no_push", 32'(push_cnt - p0), 32'd0);
        check("stall_count",   32'(bus.count),     32'd8);
`ifdef LIFO_CTRL_OVF_ERR_EN
        exp_ovf_err = 1'b1;
`else
        exp_ovf_err = 1'b0;
`endif
        check("stall_error", 32'(bus.error), 32'(exp_ovf_err));
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        step();
        bus.err_clr  = 1'b0;
        check("stall_err_clr", 32'(bus.error), 32'd0);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        wait_ov("fill_rd");
        check("fill_rd_data",     32'(bus.out_data), 32'd17);
        check("fill_rd_in_ready", 32'(bus.in_ready), 32'd1);
        check("fill_rd_count",    32'(bus.count),    32'd7);

        // Underflow, clear, and simultaneous set/clear.
        do_reset();
        p0 = pop_cnt;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        check("unf_error",    32'(bus.error),    32'd1);
        check("unf_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) step();
        check("unf_no_pop",   32'(pop_cnt - p0), 32'd0);
        check("unf_count",    32'(bus.count),    32'd0);
        check("unf_sticky",   32'(bus.error),    32'd1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("unf_cleared", 32'(bus.error), 32'd0);
        bus.rd_req  = 1'b1;
        bus.err_clr = 1'b1;
        step();
        bus.rd_req  = 1'b0;
        bus.err_clr = 1'b0;
        check("unf_set_wins", 32'(bus.error), 32'd1);

        // Push has priority over a simultaneous read request.
        do_reset();
        push_word(6'd33);
        push_word(6'd44);
        check("pri_count0", 32'(bus.count), 32'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd55;
        bus.rd_req   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("pri_push",   32'(bus.push),  32'd1);
        check("pri_nopop",  32'(bus.pop),   32'd0);
        check("pri_count1", 32'(bus.count), 32'd3);
        check("pri_dio",    32'(bus.dio),   32'd55);
        step();
        check("pri_gap_pop", 32'(bus.pop), 32'd0);
        step();
        check("pri_pop",    32'(bus.pop),   32'd1);
        check("pri_count2", 32'(bus.count), 32'd2);
        bus.rd_req = 1'b0;
        wait_ov("pri_rd");
        check("pri_rd_data", 32'(bus.out_data), 32'd55);

        // Asynchronous reset while the read sits in WAIT.
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        check("wrst_pop", 32'(bus.pop), 32'd1);
        step();
        #3;
        reset = 1'b1;
        #1;
        check("wrst_push",     32'(bus.push),      32'd0);
        check("wrst_pop0",     32'(bus.pop),       32'd0);
        check("wrst_ov",       32'(bus.out_valid), 32'd0);
        check("wrst_od",       32'(bus.out_data),  32'd0);
        check("wrst_dio",      32'(bus.dio),       32'd0);
        check("wrst_count",    32'(bus.count),     32'd0);
        check("wrst_empty",    32'(bus.empty),     32'd1);
        check("wrst_error",    32'(bus.error),     32'd0);
        check("wrst_in_ready", 32'(bus.in_ready),  32'd1);
        p0 = ov_cnt;
        step();
        reset = 1'b0;
        repeat (6) step();
        check("wrst_no_ov",   32'(ov_cnt - p0), 32'd0);
        check("wrst_count2",  32'(bus.count),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lifo_ctrl.md
Name: lifo_ctrl

Overview:
- Request-side controller that sits directly upstream of lifo_stack and drives its clk/reset/push/pop/dio, consuming its q.
- Converts a valid/ready write stream plus a read-request strobe into single-cycle push/pop pulses.
- Tracks occupancy and exports full/empty/count.
- Captures popped words into a valid-qualified output and flags underflow with a sticky error.

Parameters:
- Wl, 6, data word width; must match the attached lifo_stack.
- N, 3, address bits; stack depth DEPTH = 2**N (8 by default).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset; shared with lifo_stack.
- in_valid  input  1  write word offered.
- in_ready  output  1  controller accepts the word this cycle.
- in_data  input  Wl  word to push.
- rd_req  input  1  level read request, sampled only in IDLE.
- err_clr  input  1  clears sticky error.
- out_valid  output  1  one-cycle strobe; out_data holds a popped word.
- out_data  output  Wl  last popped word; holds until the next capture.
- push  output  1  to lifo_stack.push; registered, one-cycle pulse.
- pop  output  1  to lifo_stack.pop; registered, one-cycle pulse.
- dio  output  Wl  to lifo_stack.dio; registered, valid while push=1.
- q  input  Wl  from lifo_stack.q.
- count  output  N+1  occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- error  output  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - push, pop, out_valid, error = 0.
  - dio, out_data, count = 0.
  - empty=1, full=0.
  - Reset mid-operation aborts any pop in flight; no out_valid is produced.
- FSM states: IDLE, PUSH, POP, WAIT, CAPT.
- IDLE:
  - in_ready = !full (combinational), 0 in all other states.
  - Edge with in_valid & in_ready: dio<=in_data, push<=1, count+1, go to PUSH.
  - Otherwise, edge with rd_req & !empty: pop<=1, count-1, go to POP.
  - Otherwise, edge with rd_req & empty: error<=1, no pop, stay in IDLE.
  - Push has priority over a simultaneous rd_req; rd_req is re-sampled on the next return to IDLE.
- PUSH: push<=0, go to IDLE. One push costs 2 cycles.
- POP: pop<=0, go to WAIT. lifo_stack samples pop on this edge.
- WAIT: lifo_stack's registered q becomes valid; go to CAPT.
- CAPT: out_data<=q, out_valid<=1 for exactly one cycle, go to IDLE.
- Read latency: rd_req sampled at edge E0 → out_valid high in the cycle after E3. One read costs 4 cycles.
- count changes only at the push/pop issue edges; full/empty are decoded combinationally from count.
- No wrap: count never exceeds DEPTH and never drops below 0.
- Overflow: in_valid while full stalls (in_ready=0); data is held by the source and nothing is lost.
- error:
  - Set by underflow; cleared by err_clr.
  - If set and clear occur on the same edge, set wins.
  - error does not block further operation.

Optional Feature:
- Macro: LIFO_CTRL_OVF_ERR_EN.
- Defined: in IDLE, in_valid while full additionally sets error (same stickiness and clear rules); the stall behaviour is unchanged.
- Undefined: a full-state stall never touches error.

Test Plan:
- LIFO order: after reset, push 6'b000111, 6'b000101, 6'b010111, then three rd_req → out_data sequence 010111, 000101, 000111. count 3→0; empty=1 at end; error=0.
- Fill: 8 pushes → count=8, full=1, in_ready=0. A 9th in_valid held for 10 cycles → no push pulse. Then one rd_req → out_data equals the 8th word, in_ready returns to 1.
- Underflow: rd_req while empty → error=1, pop never asserted. err_clr pulse → error=0. Simultaneous set and clear → error=1.
- Simultaneous in_valid and rd_req in IDLE with count=2 → push issued first (count=3). The pop follows 2 cycles later and returns the just-pushed word.
- Reset asserted asynchronously during WAIT → all outputs return to reset values immediately; no out_valid follows.
- Macro check:
  - With LIFO_CTRL_OVF_ERR_EN: in_valid while full → error=1.
  - Without it: error stays 0.
